// File: rtl/pwm_duty_ramp_pkg.sv
// Shared PWM definitions: default timing, FSM encoding
// and a small clamp helper used by the ramp logic.
package pwm_duty_ramp_pkg;

  localparam int unsigned PERIOD_DEF = 5000;
  localparam int unsigned STEP_DEF   = 50;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Smaller of two 17-bit values, narrowed to 16 bits.
  // The bound b always fits in 16 bits, so no data is lost.
  function automatic logic [15:0] min16(
    input logic [16:0] a,
    input logic [16:0] b
  );
    logic [16:0] m;
    m = (a < b) ? a : b;
    return m[15:0];
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Duty/phase request handshake between a requester
// and the ramp block.
interface pwm_duty_ramp_if;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_duty;
  logic [15:0] req_phase;

  modport master (
    output req_valid,
    output req_duty,
    output req_phase,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_duty,
    input  req_phase,
    output req_ready
  );

endinterface

// File: rtl/pwm_ramp_step.sv
// One ramp step: moves cur toward target by at most STEP
// and flags when this step lands exactly on the target.
module pwm_ramp_step
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEF
) (
  input  logic [15:0] i_cur,
  input  logic [15:0] i_target,
  output logic [15:0] o_next,
  output logic        o_reached
);

  localparam logic [15:0] STEP_W = 16'(STEP);

  logic        w_up;
  logic [15:0] w_diff;

  // Distance and direction to target; snap when within STEP.
  always_comb begin
    w_up   = i_target > i_cur;
    w_diff = w_up ? (i_target - i_cur)
                  : (i_cur - i_target);
    o_reached = (w_diff <= STEP_W);
    if (o_reached)
      o_next = i_target;
    else if (w_up)
      o_next = i_cur + STEP_W;
    else
      o_next = i_cur - STEP_W;
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty ramp controller: slews the PWM high time toward a
// requested target once per PWM period and drives CR1/CR2.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEF,
  parameter int unsigned STEP   = STEP_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  period_tick,
  pwm_duty_ramp_if.slave        req,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           cr1,
  output logic [15:0]           cr2
);

  localparam logic [16:0] PER_17  = 17'(PERIOD);
  localparam logic [16:0] PERM_17 = 17'(PERIOD - 1);

  state_t      r_state;
  logic [15:0] r_cur;
  logic [15:0] r_target;
  logic [15:0] r_phase;
  logic [15:0] r_shadow;
  logic [15:0] r_cr2;
  logic        r_done;

  logic        w_accept;
  logic [15:0] w_step_next;
  logic        w_reached;
  logic [15:0] w_duty_next;
  logic [16:0] w_sum;

  pwm_ramp_step #(
    .STEP (STEP)
  ) u_step (
    .i_cur     (r_cur),
    .i_target  (r_target),
    .o_next    (w_step_next),
    .o_reached (w_reached)
  );

  // Handshake, next duty and the unwrapped CR2 sum.
  always_comb begin
    w_accept    = req.req_valid && (r_state == IDLE);
    w_duty_next = (r_state == RAMP) ? w_step_next
                                    : r_cur;
    w_sum       = {1'b0, r_shadow} + {1'b0, w_duty_next};
  end

  // Request latch, period-aligned updates and ramp FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cur    <= '0;
      r_target <= '0;
      r_phase  <= '0;
      r_shadow <= '0;
      r_cr2    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_target <= min16({1'b0, req.req_duty}, PER_17);
        r_shadow <= min16({1'b0, req.req_phase}, PERM_17);
      end
      if (period_tick) begin
        r_phase <= r_shadow;
        r_cur   <= w_duty_next;
        r_cr2   <= min16(w_sum, PER_17);
      end
      unique case (r_state)
        IDLE: begin
          if (w_accept)
            r_state <= RAMP;
        end
        RAMP: begin
          if (period_tick && w_reached) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req.req_ready = (r_state == IDLE);
  assign busy          = (r_state == RAMP);
  assign done          = r_done;
  assign cr1           = r_phase;
  assign cr2           = r_cr2;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected CR/done
// values are queued per tick and checked one cycle later.
module tb_pwm_duty_ramp;

  typedef struct packed {
    logic [15:0] cr1;
    logic [15:0] cr2;
    logic        done;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        period_tick;
  logic        busy;
  logic        done;
  logic [15:0] cr1;
  logic [15:0] cr2;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  pwm_duty_ramp_if rif ();

  pwm_duty_ramp #(
    .PERIOD (5000),
    .STEP   (50)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .period_tick (period_tick),
    .req         (rif.slave),
    .busy        (busy),
    .done        (done),
    .cr1         (cr1),
    .cr2         (cr2)
  );

  always #5 clock = ~clock;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_tick(
    input logic [15:0] c1,
    input logic [15:0] c2,
    input logic        d
  );
    exp_t e;
    e.cr1  = c1;
    e.cr2  = c2;
    e.done = d;
    sb.push_back(e);
    period_tick = 1'b1;
    @(posedge clock);
    #1;
    period_tick = 1'b0;
  endtask

  task automatic send_req(
    input  logic [15:0] duty,
    input  logic [15:0] phase,
    output bit          ok
  );
    rif.req_duty  = duty;
    rif.req_phase = phase;
    rif.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rif.req_ready === 1'b1) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    rif.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (cr1 !== 16'd0 || cr2 !== 16'd0) begin
      bad++;
      $display("FAIL reset_cr: cr1=%0d cr2=%0d want 0 0",
               cr1, cr2);
    end
    total++;
    if (rif.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b busy=%b want 1 0",
               rif.req_ready, busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: done=%b want 0", done);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_up_ramp();
    bit   ok;
    exp_t e;
    logic [15:0] ramp [4];
    ramp = '{16'd50, 16'd100, 16'd150, 16'd200};
    send_req(16'd200, 16'd0, ok);
    total++;
    if (!ok || busy !== 1'b1 || rif.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL up_accept: ok=%b busy=%b ready=%b want 1 1 0",
               ok, busy, rif.req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      idle(2);
      if (i == 1) begin
        total++;
        if (cr2 !== 16'd50) begin
          bad++;
          $display("FAIL up_hold: cr2=%0d want 50", cr2);
        end
      end
      do_tick(16'd0, ramp[i], i == 3);
      e = sb.pop_front();
      total++;
      if (cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
        bad++;
        $display("FAIL up_tick%0d: cr1=%0d cr2=%0d done=%b want %0d %0d %b",
                 i, cr1, cr2, done, e.cr1, e.cr2, e.done);
      end
    end
    idle(1);
    total++;
    if (done !== 1'b0 || rif.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL up_end: done=%b ready=%b busy=%b want 0 1 0",
               done, rif.req_ready, busy);
    end
  endtask

  task automatic test_down_ramp();
    bit   ok;
    exp_t e;
    send_req(16'd120, 16'd0, ok);
    do_tick(16'd0, 16'd150, 1'b0);
    do_tick(16'd0, 16'd120, 1'b1);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      total++;
      if (!ok || cr2 !== e.cr2 && i == 1 || cr1 !== e.cr1) begin
        bad++;
        $display("FAIL down_tick%0d: ok=%b cr1=%0d cr2=%0d want %0d %0d",
                 i, ok, cr1, cr2, e.cr1, e.cr2);
      end
    end
    total++;
    if (cr2 !== 16'd120 || done !== 1'b1) begin
      bad++;
      $display("FAIL down_done: cr2=%0d done=%b want 120 1",
               cr2, done);
    end
    idle(1);
  endtask

  task automatic test_clamp();
    bit   ok;
    exp_t e;
    int   m;
    int   n;
    bit   fin;
    send_req(16'd6000, 16'd4990, ok);
    m = 120;
    n = 0;
    fin = 1'b0;
    while (!fin && n < 200) begin
      m = (5000 - m <= 50) ? 5000 : m + 50;
      do_tick(16'd4990, 16'd5000, m == 5000);
      e = sb.pop_front();
      total++;
      if (cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
        bad++;
        $display("FAIL clamp_up%0d: cr1=%0d cr2=%0d done=%b want %0d %0d %b",
                 n, cr1, cr2, done, e.cr1, e.cr2, e.done);
      end
      fin = (m == 5000);
      n++;
    end
    idle(1);
    send_req(16'd5000, 16'd0, ok);
    do_tick(16'd0, 16'd5000, 1'b1);
    e = sb.pop_front();
    total++;
    if (!ok || cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
      bad++;
      $display("FAIL clamp_equal: cr1=%0d cr2=%0d done=%b want 0 5000 1",
               cr1, cr2, done);
    end
    idle(1);
    send_req(16'd100, 16'd7000, ok);
    m = 5000;
    n = 0;
    fin = 1'b0;
    while (!fin && n < 200) begin
      m = (m - 100 <= 50) ? 100 : m - 50;
      do_tick(16'd4999, 16'd5000, m == 100);
      e = sb.pop_front();
      total++;
      if (cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
        bad++;
        $display("FAIL clamp_phase%0d: cr1=%0d cr2=%0d done=%b want %0d %0d %b",
                 n, cr1, cr2, done, e.cr1, e.cr2, e.done);
      end
      fin = (m == 100);
      n++;
    end
    idle(1);
    send_req(16'd100, 16'd0, ok);
    do_tick(16'd0, 16'd100, 1'b1);
    e = sb.pop_front();
    total++;
    if (cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
      bad++;
      $display("FAIL clamp_back: cr1=%0d cr2=%0d done=%b want 0 100 1",
               cr1, cr2, done);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] c2 [4];
    logic        dn [4];
    c2 = '{16'd150, 16'd200, 16'd250, 16'd300};
    dn = '{1'b0, 1'b1, 1'b0, 1'b1};
    rif.req_duty  = 16'd200;
    rif.req_phase = 16'd0;
    rif.req_valid = 1'b1;
    sb.push_back('{cr1: 16'd0, cr2: 16'd100, done: 1'b0});
    period_tick = 1'b1;
    @(posedge clock);
    #1;
    period_tick = 1'b0;
    e = sb.pop_front();
    total++;
    if (cr2 !== e.cr2 || done !== e.done || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept_tick: cr2=%0d done=%b busy=%b want 100 0 1",
               cr2, done, busy);
    end
    rif.req_duty = 16'd300;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        total++;
        if (rif.req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready: ready=%b want 1", rif.req_ready);
        end
        @(posedge clock);
        #1;
        rif.req_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        end
      end
      do_tick(16'd0, c2[i], dn[i]);
      e = sb.pop_front();
      total++;
      if (cr1 !== e.cr1 || cr2 !== e.cr2 || done !== e.done) begin
        bad++;
        $display("FAIL b2b_tick%0d: cr1=%0d cr2=%0d done=%b want %0d %0d %b",
                 i, cr1, cr2, done, e.cr1, e.cr2, e.done);
      end
    end
    rif.req_valid = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_ramp();
    bit   ok;
    exp_t e;
    bit   saw_done;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    send_req(16'd200, 16'd0, ok);
    do_tick(16'd0, 16'd50, 1'b0);
    do_tick(16'd0, 16'd100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
    end
    total++;
    if (!ok || cr2 !== 16'd100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: cr2=%0d busy=%b want 100 1", cr2, busy);
    end
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (cr1 !== 16'd0 || cr2 !== 16'd0 || rif.req_ready !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: cr1=%0d cr2=%0d ready=%b busy=%b done=%b want 0 0 1 0 0",
               cr1, cr2, rif.req_ready, busy, done);
    end
    saw_done = 1'b0;
    period_tick = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    period_tick = 1'b0;
    reset = 1'b0;
    idle(2);
    if (done !== 1'b0) saw_done = 1'b1;
    total++;
    if (saw_done || cr2 !== 16'd0) begin
      bad++;
      $display("FAIL rst_no_done: saw_done=%b cr2=%0d want 0 0",
               saw_done, cr2);
    end
    send_req(16'd100, 16'd0, ok);
    do_tick(16'd0, 16'd50, 1'b0);
    e = sb.pop_front();
    total++;
    if (cr2 !== e.cr2 || done !== e.done) begin
      bad++;
      $display("FAIL rst_after1: cr2=%0d done=%b want 50 0", cr2, done);
    end
    do_tick(16'd0, 16'd100, 1'b1);
    e = sb.pop_front();
    total++;
    if (cr2 !== e.cr2 || done !== e.done) begin
      bad++;
      $display("FAIL rst_after2: cr2=%0d done=%b want 100 1", cr2, done);
    end
    idle(1);
  endtask

  initial begin
    reset         = 1'b1;
    period_tick   = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_duty  = 16'd0;
    rif.req_phase = 16'd0;
    #2;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_clamp();
    test_back_to_back();
    test_reset_mid_ramp();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: size=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
